// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, header field helpers and the
// network-interface transmitter state encoding.
package noc_pkg;

   localparam int NOC_FLIT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      SIZE    = 2'd2,
      PAYLOAD = 2'd3
   } ni_tx_state_t;

   // Header flit = {source address, destination address}, each half a flit wide.
   function automatic logic [31:0] hdr_src(input logic [63:0] flit, input int fw);
      logic [63:0] w_mask;
      w_mask = (64'd1 << (fw / 2)) - 64'd1;
      return 32'((flit >> (fw / 2)) & w_mask);
   endfunction

   function automatic logic [31:0] hdr_dst(input logic [63:0] flit, input int fw);
      logic [63:0] w_mask;
      w_mask = (64'd1 << (fw / 2)) - 64'd1;
      return 32'(flit & w_mask);
   endfunction

endpackage

// File: rtl/noc_ni_tx.sv
// NoC network-interface transmitter: descriptor + payload stream in, credit-gated
// header/size/payload flits out. Optional counters under NI_TX_STATS_EN.
module noc_ni_tx
   import noc_pkg::*;
#(
   parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
   parameter int ADDRESS    = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    clock_tx,
   output logic                    tx,
   output logic [FLIT_WIDTH-1:0]   data_o,
   input  logic                    credit_i,
   input  logic                    pkt_valid,
   output logic                    pkt_ready,
   input  logic [FLIT_WIDTH/2-1:0] pkt_dst,
   input  logic [FLIT_WIDTH-1:0]   pkt_len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [FLIT_WIDTH-1:0]   in_data,
   output logic                    pkt_done,
   output logic                    busy,
`ifdef NI_TX_STATS_EN
   output logic [31:0]             stat_pkts,
   output logic [31:0]             stat_stall,
`endif
   output ni_tx_state_t            dbg_state
);

   localparam int HALF = FLIT_WIDTH / 2;
   localparam logic [HALF-1:0] L_SRC = HALF'(ADDRESS);

   ni_tx_state_t            r_state;
   logic                    r_tx;
   logic [FLIT_WIDTH-1:0]   r_data;
   logic                    r_pkt_done;
   logic [FLIT_WIDTH-1:0]   r_len;
   logic [FLIT_WIDTH-1:0]   r_remaining;

   logic w_xfer;
   logic w_in_ready;
   logic w_in_hs;

   // Handshakes: a flit moves on tx && credit_i; a descriptor on pkt_valid && pkt_ready;
   // a payload word on in_valid && in_ready. All sampled at the rising clock edge.
   assign w_xfer     = r_tx && credit_i;
   // The first payload word may be taken on the same edge the size flit leaves.
   assign w_in_ready = ((r_state == PAYLOAD) && (r_remaining != '0) && (!r_tx || credit_i)) ||
                       ((r_state == SIZE) && (r_len != '0) && credit_i);
   assign w_in_hs    = in_valid && w_in_ready;

   assign clock_tx  = clock;
   assign tx        = r_tx;
   assign data_o    = r_data;
   assign pkt_done  = r_pkt_done;
   assign pkt_ready = (r_state == IDLE) && !reset;
   assign in_ready  = w_in_ready;
   assign busy      = (r_state != IDLE);
   assign dbg_state = r_state;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_tx        <= 1'b0;
         r_data      <= '0;
         r_pkt_done  <= 1'b0;
         r_len       <= '0;
         r_remaining <= '0;
      end else begin
         r_pkt_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (pkt_valid) begin
                  r_len   <= pkt_len;
                  r_data  <= {L_SRC, pkt_dst};
                  r_tx    <= 1'b1;
                  r_state <= HEADER;
               end
            end
            HEADER: begin
               if (w_xfer) begin
                  r_data  <= r_len;
                  r_state <= SIZE;
               end
            end
            SIZE: begin
               if (w_xfer) begin
                  if (r_len == '0) begin
                     r_tx       <= 1'b0;
                     r_pkt_done <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_state <= PAYLOAD;
                     if (in_valid) begin
                        r_data      <= in_data;
                        r_tx        <= 1'b1;
                        r_remaining <= r_len - FLIT_WIDTH'(1);
                     end else begin
                        r_tx        <= 1'b0;
                        r_remaining <= r_len;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (w_in_hs) begin
                  r_data      <= in_data;
                  r_tx        <= 1'b1;
                  r_remaining <= r_remaining - FLIT_WIDTH'(1);
               end else if (w_xfer) begin
                  r_tx <= 1'b0;
                  if (r_remaining == '0) begin
                     r_pkt_done <= 1'b1;
                     r_state    <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef NI_TX_STATS_EN
   logic [31:0] r_stat_pkts;
   logic [31:0] r_stat_stall;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stat_pkts  <= '0;
         r_stat_stall <= '0;
      end else begin
         if (r_pkt_done && (r_stat_pkts != '1)) begin
            r_stat_pkts <= r_stat_pkts + 32'd1;
         end
         if (r_tx && !credit_i && (r_stat_stall != '1)) begin
            r_stat_stall <= r_stat_stall + 32'd1;
         end
      end
   end

   assign stat_pkts  = r_stat_pkts;
   assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_noc_ni_tx.sv
// Bench for noc_ni_tx (FLIT_WIDTH=16, ADDRESS=0x11); stats checks apply when
// NI_TX_STATS_EN is defined.
module tb_noc_ni_tx;
   import noc_pkg::*;

   localparam int         FW   = 16;
   localparam logic [7:0] ADDR = 8'h11;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          credit_i = 1'b0;
   logic          pkt_valid = 1'b0;
   logic [7:0]    pkt_dst = '0;
   logic [15:0]   pkt_len = '0;
   logic          in_valid = 1'b0;
   logic [15:0]   in_data = '0;
   logic          clock_tx, tx, pkt_ready, in_ready, pkt_done, busy;
   logic [15:0]   data_o;
   ni_tx_state_t  dbg_state;
`ifdef NI_TX_STATS_EN
   logic [31:0]   stat_pkts, stat_stall;
`endif

   noc_ni_tx #(.FLIT_WIDTH(FW), .ADDRESS(int'(ADDR))) dut (
      .clock(clock), .reset(reset), .clock_tx(clock_tx), .tx(tx), .data_o(data_o),
      .credit_i(credit_i), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_dst(pkt_dst), .pkt_len(pkt_len), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .pkt_done(pkt_done), .busy(busy),
`ifdef NI_TX_STATS_EN
      .stat_pkts(stat_pkts), .stat_stall(stat_stall),
`endif
      .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   // Reference model: ordered flits still owed by the DUT, and flits per packet.
   logic [15:0] exp_q[$];
   int          exp_cnt_q[$];
   logic [15:0] cur_pl[$];
   int errors = 0;
   int checks = 0;

   int          pkt_flit_cnt = 0;
   int          hs_cnt = 0;
   int          cyc = 0;
   int          first_cyc = 0;
   int          last_span = 0;
   bit          prev_final = 0;
   bit          prev_hold = 0;
   bit          gap_seen = 1;
   logic [15:0] prev_data = '0;

   int credit_force = 1;
   int stall_left = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   function automatic logic [15:0] hdr(input logic [7:0] d);
      return {ADDR, d};
   endfunction

   task automatic clear_model();
      exp_q.delete();
      exp_cnt_q.delete();
      cur_pl.delete();
      pkt_flit_cnt = 0;
      hs_cnt = 0;
      prev_final = 0;
      prev_hold = 0;
      gap_seen = 1;
   endtask

   always @(posedge clock) begin
      #1;
      if (stall_left > 0) begin
         credit_i = 1'b0;
         stall_left--;
      end else if (credit_force >= 0) begin
         credit_i = credit_force[0];
      end else begin
         credit_i = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: everything observed here is a flit leaving at the next rising edge.
   always @(negedge clock) begin
      if (reset) begin
         clear_model();
      end else begin
         bit ok;
         cyc++;
         check("pkt_done", {31'd0, pkt_done}, {31'd0, prev_final});
         prev_final = 0;
         if (prev_hold) begin
            check("hold_tx", {31'd0, tx}, 32'd1);
            check("hold_data", {16'd0, data_o}, {16'd0, prev_data});
         end
         if (in_ready) begin
            ok = (exp_cnt_q.size() > 0) && (pkt_flit_cnt >= 1) && (hs_cnt < exp_cnt_q[0] - 2);
            check("in_ready_legal", {31'd0, ok}, 32'd1);
         end
         if (in_valid && in_ready) hs_cnt++;
         if (!tx) gap_seen = 1;
         if (tx && credit_i) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_flit");
            end else begin
               check("flit", {16'd0, data_o}, {16'd0, exp_q.pop_front()});
            end
            if (pkt_flit_cnt == 0) begin
               check("gap_before_header", {31'd0, gap_seen}, 32'd1);
               check("hdr_src", hdr_src({48'd0, data_o}, FW), {24'd0, ADDR});
               first_cyc = cyc;
            end
            gap_seen = 0;
            pkt_flit_cnt++;
            if (exp_cnt_q.size() > 0 && pkt_flit_cnt == exp_cnt_q[0]) begin
               check("payload_hs_count", hs_cnt, pkt_flit_cnt - 2);
               void'(exp_cnt_q.pop_front());
               last_span = cyc - first_cyc;
               pkt_flit_cnt = 0;
               hs_cnt = 0;
               prev_final = 1;
            end
         end
         prev_hold = tx && !credit_i;
         prev_data = data_o;
      end
   end

   task automatic send_desc(input logic [7:0] dst, input int len);
      int t = 0;
      cur_pl.delete();
      for (int i = 0; i < len; i++) cur_pl.push_back(16'($urandom));
      @(posedge clock); #1;
      pkt_valid = 1'b1;
      pkt_dst   = dst;
      pkt_len   = 16'(len);
      forever begin
         @(negedge clock);
         if (pkt_ready) break;
         t++;
         if (t > 500) begin
            fail_now("desc_timeout");
            pkt_valid = 1'b0;
            return;
         end
      end
      exp_q.push_back(hdr(dst));
      exp_q.push_back(16'(len));
      foreach (cur_pl[i]) exp_q.push_back(cur_pl[i]);
      exp_cnt_q.push_back(len + 2);
      @(posedge clock); #1;
      pkt_valid = 1'b0;
      pkt_dst   = 8'($urandom);
      pkt_len   = 16'($urandom);
   endtask

   // mode 0: in_valid always high, 1: one idle cycle between words, 2: random
   task automatic drive_payload(input int mode, input int max_hs);
      int n = 0;
      while (cur_pl.size() > 0 && n < max_hs) begin
         int t = 0;
         bit done = 0;
         in_data = cur_pl.pop_front();
         if (mode == 1 && n > 0) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
         end
         while (!done) begin
            in_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            if (in_valid && in_ready) begin
               done = 1;
            end else begin
               t++;
               if (t > 500) begin
                  fail_now("payload_timeout");
                  in_valid = 1'b0;
                  return;
               end
            end
            @(posedge clock); #1;
         end
         n++;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] dst, input int len, input int mode);
      send_desc(dst, len);
      drive_payload(mode, len);
   endtask

   task automatic wait_done();
      int t = 0;
      forever begin
         @(negedge clock);
         if (exp_q.size() == 0 && exp_cnt_q.size() == 0 && !busy) break;
         t++;
         if (t > 3000) begin
            fail_now("drain_timeout");
            return;
         end
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock); #1;
      reset     = 1'b1;
      pkt_valid = 1'b0;
      in_valid  = 1'b0;
      clear_model();
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_tx", {31'd0, tx}, 32'd0);
      check("rst_data", {16'd0, data_o}, 32'd0);
      check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      check("clock_tx_low", {31'd0, clock_tx}, {31'd0, clock});
`ifdef NI_TX_STATS_EN
      check("rst_stat_pkts", stat_pkts, 32'd0);
      check("rst_stat_stall", stat_stall, 32'd0);
`endif
      @(posedge clock); #1;
      check("clock_tx_high", {31'd0, clock_tx}, {31'd0, clock});
      reset = 1'b0;
      @(negedge clock);
      check("idle_pkt_ready", {31'd0, pkt_ready}, 32'd1);

      // 3-flit packet at full credit: five back-to-back flits
      send_pkt(8'h22, 3, 0);
      wait_done();
      check("span_len3", last_span, 32'd4);

      // zero-length packet: header and size only
      send_pkt(8'h22, 0, 0);
      wait_done();
      check("span_len0", last_span, 32'd1);

      // four stall cycles on the size flit
      do_reset();
      send_desc(8'h22, 3);
      #1 stall_left = 4;
      drive_payload(0, 3);
      wait_done();
`ifdef NI_TX_STATS_EN
      check("stat_stall_4", stat_stall, 32'd4);
`endif

      // alternating in_valid produces bubbles
      send_pkt(8'h35, 4, 1);
      wait_done();

      // reset while the second payload flit is on tx
      send_desc(8'h22, 4);
      drive_payload(0, 2);
      #1 reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      clear_model();
      @(negedge clock);
      check("mid_rst_tx", {31'd0, tx}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
      send_pkt(8'h22, 3, 0);
      wait_done();
      check("post_rst_span", last_span, 32'd4);

      // back-to-back single-flit packets
      do_reset();
      send_pkt(8'h44, 1, 0);
      send_pkt(8'h55, 1, 0);
      wait_done();
      repeat (2) @(negedge clock);
`ifdef NI_TX_STATS_EN
      check("stat_pkts_2", stat_pkts, 32'd2);
`endif

      // random traffic with random credit and payload gaps
      credit_force = -1;
      for (int k = 0; k < 25; k++) begin
         send_pkt(8'($urandom), $urandom_range(0, 6), $urandom_range(0, 2));
      end
      wait_done();
      check("final_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/noc_ni_tx.md
Name: noc_ni_tx

Overview:
Network-interface transmitter that injects packets into a router's local input port (rx / data_in / credit_o).
- Core side: a packet descriptor (destination, payload length) followed by a valid/ready payload stream.
- Network side: a credit-gated flit sequence of header, size, then payload.
- Sits between a processing element and the router local port, one instance per tile, in the packet simulator hardware.

Parameters:
FLIT_WIDTH, 16, flit and data width in bits; must be even.
ADDRESS, 0, this tile's router address; placed in the header upper half as source.

Ports:
clock  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
clock_tx  out  1  forwarded clock to the router rx side; equals clock, combinational.
tx  out  1  flit valid toward router rx.
data_o  out  FLIT_WIDTH  flit toward router data_in.
credit_i  in  1  router credit_o; high means the router accepts a flit this cycle.
pkt_valid  in  1  core presents a packet descriptor.
pkt_ready  out  1  descriptor accepted when pkt_valid && pkt_ready.
pkt_dst  in  FLIT_WIDTH/2  destination router address.
pkt_len  in  FLIT_WIDTH  payload flit count; 0 is legal.
in_valid  in  1  payload flit valid.
in_ready  out  1  payload flit accepted when in_valid && in_ready.
in_data  in  FLIT_WIDTH  payload flit.
pkt_done  out  1  one-cycle pulse when the last flit of a packet is accepted by the router.
busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: tx=0, data_o=0, pkt_ready=0 during reset, in_ready=0, pkt_done=0, busy=0, FSM=IDLE, remaining=0.
- Flit transfer rule: a flit transfers at the rising edge where tx=1 && credit_i=1.
  - tx and data_o are registered.
  - While tx=1 && credit_i=0, data_o holds and no state advances.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE:
  - pkt_ready=1.
  - On descriptor handshake: latch dst and len, go to HEADER.
  - Next cycle: tx=1, data_o={ADDRESS[FLIT_WIDTH/2-1:0], dst}.
- HEADER: on transfer, load data_o=len with tx=1, go to SIZE.
- SIZE, on transfer:
  - If len==0: tx=0, pkt_done=1 next cycle, go to IDLE.
  - Else: remaining=len, go to PAYLOAD, tx=0 until a payload flit is loaded.
- PAYLOAD:
  - in_ready = (remaining!=0) && (!tx || credit_i), i.e. the output register is empty or being emptied this edge.
  - On in handshake: data_o=in_data, tx=1, remaining-=1.
  - If no in handshake while the register empties: tx=0 (bubble).
  - When the final payload flit transfers (remaining==0 and transfer): tx=0, pkt_done pulses, go to IDLE.
- Throughput:
  - One flit per cycle with continuous credit and in_valid.
  - Minimum one IDLE cycle between packets (tx=0 gap).
- Latency: descriptor handshake at edge N → header on tx at N+1. The in handshake on the same edge as the previous flit transfer loads the next flit with no bubble.
- Widths: remaining is FLIT_WIDTH bits; length 2^FLIT_WIDTH-1 is the maximum, and there is no wrap.
- Reset mid-packet: the packet is abandoned; tx=0 the cycle after reset is sampled; partial packet is not completed.
- Descriptor fields are ignored while busy; pkt_ready=0 outside IDLE.
- credit_i is ignored when tx=0.

Optional Feature:
- Macro: NI_TX_STATS_EN.
- When defined:
  - Adds outputs stat_pkts (32 bits), count of pkt_done pulses.
  - Adds stat_stall (32 bits), cycles with tx=1 && credit_i=0.
  - Both saturate at all-ones and clear on reset.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package noc_pkg holds:
  - the FLIT_WIDTH default constant;
  - the header field split helpers (src/dst halves);
  - the ni_tx_state_t enum {IDLE, HEADER, SIZE, PAYLOAD}.
- No sub-module: the FSM plus the output register is one module. The stats counters sit in an ifdef block inside it.

Test Plan:
- ADDRESS=0x11, pkt_dst=0x22, pkt_len=3, payload A,B,C, credit_i=1 constant → data_o 0x1122, 0x0003, A, B, C on 5 consecutive tx cycles; pkt_done one cycle after C transfers.
- pkt_len=0 → exactly 2 flits (0x1122, 0x0000), then pkt_done; in_ready never asserted.
- Same 3-flit packet, credit_i low for 4 cycles while the size flit is presented → data_o holds 0x0003 for those cycles; no flit lost or duplicated; stat_stall=4 with NI_TX_STATS_EN.
- in_valid toggled 1,0,1,0 during payload → tx shows bubbles; flit order preserved; remaining reaches 0 after exactly len handshakes.
- Reset asserted while the 2nd payload flit is on tx → tx=0 next cycle, busy=0, pkt_ready=1; a new packet afterwards transmits correctly from the header.
- Two back-to-back descriptors (len=1 each) → second header appears only after ≥1 tx=0 cycle; stat_pkts=2.
